// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Two-port round-robin arbiter in front of a bank of 2^AW loadable
//   WIDTH-bit registers. Each granted access is either one read or one
//   write. Every access runs IDLE -> ACCESS -> ACK, so it takes 3 cycles.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req0/req1           access request, one per port
//   load0/load1         1 = write, 0 = read (sampled together with req)
//   addr0/addr1         register index
//   in0/in1             write data
//   gnt0/gnt1           high during the ACCESS cycle of that port's access
//   ack0/ack1           one-cycle completion pulse
//   out0/out1           read result; holds until the next ack to that port

// Loadable storage register: one element of the bank.
module reg_bank_arbiter_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       q_o <= '0;
        else if (load_i) q_o <= d_i;
    end
endmodule

module reg_bank_arbiter #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             load0,
    input  logic             load1,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;     // 0 = port 0 owns the access
    logic             last_q, last_d;   // port served most recently
    logic             load_q, load_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;

    logic [DEPTH-1:0]            bank_we;
    logic [DEPTH-1:0][WIDTH-1:0] bank_q;
    logic [WIDTH-1:0]            acc_val;

    // Bank: only the addressed register loads, and only in ACCESS on a write.
    for (genvar g = 0; g < DEPTH; g++) begin : g_bank
        assign bank_we[g] = (state_q == ACCESS) && load_q && (addr_q == AW'(g));
        reg_bank_arbiter_reg #(.WIDTH(WIDTH)) u_reg (
            .clk    (clk),
            .reset  (reset),
            .load_i (bank_we[g]),
            .d_i    (data_q),
            .q_o    (bank_q[g])
        );
    end

    // Value the bank holds after the ACCESS edge: a write returns its own data.
    assign acc_val = load_q ? data_q : bank_q[addr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;   // port 0 wins the first tie
            load_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        load_d  = load_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to the port not served last; otherwise the lone requester.
                    win_d   = (req0 && req1) ? ~last_q : req1;
                    load_d  = win_d ? load1 : load0;
                    addr_d  = win_d ? addr1 : addr0;
                    data_d  = win_d ? in1   : in0;
                    gnt0_d  = ~win_d;
                    gnt1_d  = win_d;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                if (win_q) begin
                    ack1_d = 1'b1;
                    out1_d = acc_val;
                end else begin
                    ack0_d = 1'b1;
                    out0_d = acc_val;
                end
                last_d  = win_q;
                state_d = ACK;
            end
            ACK: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign out0 = out0_q;
    assign out1 = out1_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;
    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 0, req1 = 0, load0 = 0, load1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [W-1:0]  in0 = '0, in1 = '0;
    logic          gnt0, gnt1, ack0, ack1;
    logic [W-1:0]  out0, out1;

    reg_bank_arbiter #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .load0(load0), .load1(load1),
        .addr0(addr0), .addr1(addr1), .in0(in0), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .out0(out0), .out1(out1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [W-1:0] data;
    } sb_t;

    sb_t          sb[$];
    int           ack_log[$];
    logic [W-1:0] mem [8];
    logic [W-1:0] eo0, eo1;
    int           total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        eo0 = '0;
        eo1 = '0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One access from port p; returns edges waited from req to gnt.
    task automatic xact(input int p, input bit ld, input logic [AW-1:0] a,
                        input logic [W-1:0] d, output int lat);
        bit g;
        int n;
        logic [W-1:0] e;
        @(negedge clk);
        if (p == 0) begin req0 = 1; load0 = ld; addr0 = a; in0 = d; end
        else        begin req1 = 1; load1 = ld; addr1 = a; in1 = d; end
        n = 0;
        g = 0;
        while (!g && n < 20) begin
            @(posedge clk); #1;
            n++;
            g = (p == 0) ? gnt0 : gnt1;
        end
        lat = n;
        chk($sformatf("gnt%0d_seen", p), 32'(g), 1);
        if (g) begin
            if (ld) mem[a] = d;
            e = mem[a];
            sb.push_back('{port: p, data: e});
            @(posedge clk); #1;
            chk($sformatf("ack%0d", p), 32'((p == 0) ? ack0 : ack1), 1);
            chk($sformatf("gnt%0d_drop", p), 32'((p == 0) ? gnt0 : gnt1), 0);
        end
        if (p == 0) req0 = 0; else req1 = 0;
        @(posedge clk);
    endtask

    // Scoreboard: every ack pops one expected result.
    always @(negedge clk) begin
        if (!reset && (ack0 || ack1)) begin
            automatic int p = ack1 ? 1 : 0;
            chk("ack_both", 32'(ack0 && ack1), 0);
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                automatic sb_t e = sb.pop_front();
                chk("ack_port", 32'(p), 32'(e.port));
                chk("out_val", 32'(p ? out1 : out0), 32'(e.data));
                chk("other_out", 32'(p ? out0 : out1), 32'(p ? eo0 : eo1));
                if (p) eo1 = e.data; else eo0 = e.data;
            end
            ack_log.push_back(p);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, dummy;
        clear_model();
        // reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 32'({gnt0, gnt1, ack0, ack1}), 0);
        chk("rst_out0", 32'(out0), 0);
        chk("rst_out1", 32'(out1), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("idle_ctl", 32'({gnt0, gnt1, ack0, ack1}), 0);
            chk("idle_out", 32'({out0, out1}), 0);
        end

        // write then read on port 0
        xact(0, 1, 3, 16'h1234, l0);
        chk("wr_lat", 32'(l0), 1);
        xact(0, 0, 3, 16'h0000, l0);
        chk("rd_lat", 32'(l0), 1);

        // tie right after reset: port 0 first, port 1 three edges later
        do_reset();
        fork
            xact(0, 1, 1, 16'hAAAA, l0);
            xact(1, 1, 2, 16'h5555, l1);
        join
        chk("tie_lat0", 32'(l0), 1);
        chk("tie_lat1", 32'(l1), 4);
        xact(0, 0, 1, 16'h0, dummy);
        xact(1, 0, 2, 16'h0, dummy);

        // fairness: both ports keep requesting reads
        ack_log.delete();
        fork
            begin for (int i = 0; i < 2; i++) xact(0, 0, AW'(i + 1), 16'h0, dummy); end
            begin for (int i = 0; i < 2; i++) xact(1, 0, AW'(i + 1), 16'h0, dummy); end
        join
        chk("fair_count", 32'(ack_log.size()), 4);
        for (int i = 1; i < ack_log.size(); i++)
            chk("fair_alt", 32'(ack_log[i] != ack_log[i-1]), 1);

        // port isolation
        xact(1, 1, 5, 16'h0F0F, dummy);
        xact(1, 0, 5, 16'h0, dummy);
        xact(0, 1, 5, 16'h0001, dummy);
        chk("iso_out1", 32'(out1), 32'h0F0F);
        xact(1, 0, 5, 16'h0, dummy);

        // reset during ACCESS: write is lost, no ack
        @(negedge clk);
        req1 = 1; load1 = 1; addr1 = 7; in1 = 16'hBEEF;
        @(posedge clk); #1;
        chk("mid_gnt1", 32'(gnt1), 1);
        #2 reset = 1'b1;
        #1 chk("mid_rst_gnt", 32'(gnt1), 0);
        req1 = 0;
        #2 reset = 1'b0;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_no_ack", 32'({ack0, ack1, gnt0, gnt1}), 0);
        end
        xact(0, 0, 7, 16'h0, dummy);
        chk("mid_rd7", 32'(out0), 0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
